// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Routes a valid/ready input stream to one of four output channels chosen by
// {address1, address0}. Each channel is a one-word register with its own full
// flag, so a stalled channel never blocks traffic addressed to the others.
// A channel that is being drained can be refilled in the same cycle without a
// bubble.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears flags, data and counter)
//   in_valid    input word present
//   in_ready    input word accepted this cycle (combinational, ignores in_valid)
//   address0    channel select LSB
//   address1    channel select MSB
//   in_data     input word
//   out_valid   per-channel full flags, bit k = channel k
//   out_ready   per-channel sink accept, bit k = channel k
//   out0..out3  per-channel registered data
//   xfer_count  number of accepted input words, modulo 256
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             address0,
    input  logic             address1,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [7:0]       xfer_count
);

    // Two-bit channel index to one-hot channel mask.
    function automatic logic [3:0] decode_sel(input logic [1:0] sel);
        logic [3:0] onehot;
        case (sel)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    logic [1:0]       sel_s;
    logic [3:0]       sel_onehot_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic [3:0]       wr_en_s;
    logic [3:0]       rd_en_s;
    logic [3:0]       full_nxt_s;
    logic [3:0]       full_r;
    logic [WIDTH-1:0] data_r [4];
    logic [7:0]       count_r;

    assign sel_s = {address1, address0};

    // Handshake decode: the selected channel can take a word if it is empty
    // or is being emptied by its sink in this same cycle.
    always_comb begin
        sel_onehot_s = decode_sel(sel_s);
        in_ready_s   = (|(sel_onehot_s & ~full_r)) | (|(sel_onehot_s & out_ready));
        in_xfer_s    = in_valid & in_ready_s;
        if (in_xfer_s) begin
            wr_en_s = sel_onehot_s;
        end else begin
            wr_en_s = 4'b0000;
        end
        rd_en_s      = full_r & out_ready;
        // A write wins over a simultaneous read so refill-while-drain keeps the flag set.
        full_nxt_s   = wr_en_s | (full_r & ~rd_en_s);
    end

    // Full flags per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 4'b0000;
        end else begin
            full_r <= full_nxt_s;
        end
    end

    // Channel data registers; data is kept after drain and only changes on a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en_s[k]) begin
                    data_r[k] <= in_data;
                end else begin
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    // Accepted-word counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (in_xfer_s) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = full_r;
    assign out0       = data_r[0];
    assign out1       = data_r[1];
    assign out2       = data_r[2];
    assign out3       = data_r[3];
    assign xfer_count = count_r;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Scoreboard bench for stream_demux. The stimulus process pushes every word it
// expects to be accepted into a per-channel queue; a separate monitor process
// compares the channel outputs against the queue heads each cycle and pops a
// word whenever the sink takes it. Each channel is modelled simply as a queue
// of capacity one: the input is accepted when, after this cycle's drain, the
// addressed queue is empty.
// -----------------------------------------------------------------------------
module tb_stream_demux;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         address0;
    logic         address1;
    logic [W-1:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out0, out1, out2, out3;
    logic [7:0]   xfer_count;

    stream_demux #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address0   (address0),
        .address1   (address1),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [W-1:0] wq_t [$];
    wq_t          exp_q [4];
    logic [W-1:0] last_wr [4];
    int           exp_count;
    bit           mon_en;
    int           checks;
    int           errors;

    logic [W-1:0] outs [4];
    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // Monitor: shortly after each falling edge, before stimulus settles the
    // handshake, compare outputs with the model and retire drained words.
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                chk("out_valid", k, int'(out_valid[k]), int'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0) begin
                    chk("out_data", k, int'(outs[k]), int'(exp_q[k][0]));
                    if (out_ready[k]) begin
                        void'(exp_q[k].pop_front());
                    end
                end else begin
                    chk("out_hold", k, int'(outs[k]), int'(last_wr[k]));
                end
            end
            chk("xfer_count", 0, int'(xfer_count), exp_count % 256);
        end
    end

    // One clock of stimulus: drive at the falling edge, then check in_ready
    // against the model and record the word if it will be accepted.
    task automatic cycle(input bit v, input int sel, input logic [W-1:0] d, input logic [3:0] ordy);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = v;
        address0  = sel[0];
        address1  = sel[1];
        in_data   = d;
        out_ready = ordy;
        #2;
        exp_rdy = (exp_q[sel].size() == 0);
        chk("in_ready", sel, int'(in_ready), int'(exp_rdy));
        if (v && exp_rdy) begin
            exp_q[sel].push_back(d);
            last_wr[sel] = d;
            exp_count++;
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_wr[k] = '0;
        end
        exp_count = 0;
    endtask

    // Explicit post-edge check of a specific scenario outcome.
    task automatic post_edge(input string name, input logic [3:0] v, input int ch, input logic [W-1:0] d, input int cnt);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 0, int'(out_valid), int'(v));
        chk({name, "_data"}, ch, int'(outs[ch]), int'(d));
        chk({name, "_count"}, 0, int'(xfer_count), cnt);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        address0  = 1'b0;
        address1  = 1'b0;
        in_data   = '0;
        out_ready = 4'b0000;
        clear_model();

        // Reset state, including in_ready high while held in reset.
        #2;
        chk("rst_valid", 0, int'(out_valid), 0);
        chk("rst_count", 0, int'(xfer_count), 0);
        chk("rst_ready", 0, int'(in_ready), 1);
        for (int k = 0; k < 4; k++) chk("rst_out", k, int'(outs[k]), 0);
        #10;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic route to channel 2.
        cycle(1'b1, 2, 8'hA5, 4'b0000);
        post_edge("route", 4'b0100, 2, 8'hA5, 1);
        cycle(1'b0, 0, 8'h00, 4'b0100);

        // Backpressure on a stalled channel 1.
        cycle(1'b1, 1, 8'h11, 4'b0000);
        cycle(1'b1, 1, 8'h22, 4'b0000);
        chk("stall_ready", 1, int'(in_ready), 0);
        post_edge("stall", 4'b0010, 1, 8'h11, 2);

        // Channel 3 still accepts while channel 1 is stalled.
        cycle(1'b1, 3, 8'h33, 4'b0000);
        chk("nonblock_ready", 3, int'(in_ready), 1);
        post_edge("nonblock", 4'b1010, 3, 8'h33, 3);

        // Refill channel 0 while it drains.
        cycle(1'b1, 0, 8'h01, 4'b0000);
        cycle(1'b1, 0, 8'h02, 4'b0001);
        chk("refill_ready", 0, int'(in_ready), 1);
        post_edge("refill", 4'b1011, 0, 8'h02, 5);
        cycle(1'b0, 0, 8'h00, 4'b1111);

        // Randomized traffic and backpressure.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  W'($urandom), 4'($urandom));
        end

        // Async reset mid-stream with every channel full.
        cycle(1'b0, 0, 8'h00, 4'b1111);
        for (int k = 0; k < 4; k++) cycle(1'b1, k, 8'hC0 + 8'(k), 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("arst_valid", 0, int'(out_valid), 0);
        chk("arst_count", 0, int'(xfer_count), 0);
        chk("arst_ready", 0, int'(in_ready), 1);
        for (int k = 0; k < 4; k++) chk("arst_out", k, int'(outs[k]), 0);
        clear_model();
        // A valid word offered during reset must not be recorded.
        in_valid = 1'b1;
        address0 = 1'b1;
        address1 = 1'b0;
        in_data  = 8'h55;
        @(negedge clk);
        #1;
        chk("inrst_count", 0, int'(xfer_count), 0);
        chk("inrst_valid", 0, int'(out_valid), 0);
        in_valid = 1'b0;
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Counter wrap: 256 words to rotating channels, sinks always ready.
        for (int i = 0; i < 255; i++) cycle(1'b1, i % 4, W'($urandom), 4'b1111);
        post_edge("wrap255", 4'b0100, 2, last_wr[2], 255);
        cycle(1'b1, 255 % 4, W'($urandom), 4'b1111);
        post_edge("wrap0", 4'b1000, 3, last_wr[3], 0);
        cycle(1'b0, 0, 8'h00, 4'b1111);
        cycle(1'b0, 0, 8'h00, 4'b0000);
        cycle(1'b0, 0, 8'h00, 4'b0000);

        for (int k = 0; k < 4; k++) chk("drained", k, exp_q[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the input and each output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  input word present.
REQ-005 Port: in_ready  output  1  input word accepted this cycle when in_valid=1.
REQ-006 Port: address0  input  1  channel select bit 0 (LSB), sampled with in_data.
REQ-007 Port: address1  input  1  channel select bit 1 (MSB), sampled with in_data.
REQ-008 Port: in_data  input  WIDTH  input word.
REQ-009 Port: out_valid  output  4  per-channel word-present flags; bit k = channel k.
REQ-010 Port: out_ready  input  4  per-channel sink-accept flags; bit k = channel k.
REQ-011 Port: out0, out1, out2, out3  output  WIDTH each  per-channel registered data.
REQ-012 Port: xfer_count  output  8  total input words accepted since reset, modulo 256.

Function
REQ-013 Channel index sel = {address1, address0}; sel 0..3 maps to out0..out3.
REQ-014 Each channel SHALL hold exactly one word in a register with its own full flag; out_valid[k] equals full flag k.
REQ-015 Input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be combinational: 1 when channel sel is empty, or full with out_ready[sel]=1 in the same cycle; otherwise 0.
REQ-017 in_ready SHALL depend only on sel, full flags and out_ready; it SHALL NOT depend on in_valid.
REQ-018 On input transfer, in_data SHALL be written to out<sel> and full flag sel set; visible on outputs the following cycle (latency 1).
REQ-019 Output transfer on channel k SHALL occur on a rising edge when out_valid[k]=1 and out_ready[k]=1; full flag k then clears unless refilled that cycle.
REQ-020 Simultaneous input transfer to and output transfer from the same channel SHALL leave the flag set and replace the data with the new word (no bubble, no loss).
REQ-021 Channels are independent: a full, stalled channel SHALL NOT block input transfers addressed to other channels.
REQ-022 outK data SHALL hold its value while out_valid[k]=1 and out_ready[k]=0; no input write is allowed to a full, stalled channel.
REQ-023 outK data value when out_valid[k]=0 is don't-care for sinks but SHALL remain the last written word (no clearing on drain).
REQ-024 xfer_count SHALL increment by 1 on each input transfer and wrap 255 -> 0.
REQ-025 Address or data changes while in_valid=1 and in_ready=0 SHALL be permitted; only values at the transfer edge matter.
REQ-026 out_ready[k] asserted with out_valid[k]=0 SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, clear all four full flags, force out_valid=4'b0000, out0..out3 to 0, xfer_count to 0.
REQ-028 While rst_n=0, in_ready SHALL be 1 (all channels empty) but no transfer SHALL be recorded.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words; first edge after rst_n rises behaves as post-reset idle.

Verification
REQ-030 Basic route: reset, then in_valid=1, sel=2, in_data=8'hA5, out_ready=0 -> next cycle out_valid=4'b0100, out2=8'hA5, xfer_count=1.
REQ-031 Stall/backpressure: channel 1 full with 8'h11, out_ready[1]=0, drive sel=1 data 8'h22 -> in_ready=0, out1 stays 8'h11, xfer_count unchanged.
REQ-032 Non-blocking: channel 1 stalled full, drive sel=3 data 8'h33 -> in_ready=1, next cycle out_valid=4'b1010, out3=8'h33.
REQ-033 Refill-while-drain: channel 0 full 8'h01, out_ready[0]=1, drive sel=0 data 8'h02 -> in_ready=1, next cycle out_valid[0]=1, out0=8'h02.
REQ-034 Counter wrap: 256 accepted words to rotating channels with out_ready=4'b1111 -> xfer_count returns to 0, every word appears once on its channel in order.
REQ-035 Async reset mid-stream: all channels full, pulse rst_n low between edges -> out_valid=0, outs=0, xfer_count=0 before the next edge.
